// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared widths, status-flag bit positions and ALU opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int DATA_W = 16;
    localparam int RF_AW  = 4;
    localparam int DM_AW  = 8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_PASS = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_NOT  = 3'b110,
        ALU_INC  = 3'b111
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/datapath_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : datapath_unit_if
// Description : Control word from the control unit and datapath observation.
// Revision    : 1.0 - initial release
// ============================================================================
interface datapath_unit_if #(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int RF_AW  = datapath_pkg::RF_AW,
    parameter int DM_AW  = datapath_pkg::DM_AW
);
    logic [DM_AW-1:0]  D_Addr;
    logic              D_Wr;
    logic              RF_s;
    logic [RF_AW-1:0]  RF_W_Addr;
    logic              RF_W_en;
    logic [RF_AW-1:0]  RF_Ra_Addr;
    logic [RF_AW-1:0]  RF_Rb_Addr;
    logic [2:0]        ALU_s0;
    logic [DATA_W-1:0] Ra_Data;
    logic [DATA_W-1:0] Rb_Data;
    logic [DATA_W-1:0] ALU_Out;
    logic [DATA_W-1:0] Mem_Q;
    logic [2:0]        Flags;

    modport master (
        output D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
        input  Ra_Data, Rb_Data, ALU_Out, Mem_Q, Flags
    );

    modport slave (
        input  D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
        output Ra_Data, Rb_Data, ALU_Out, Mem_Q, Flags
    );
endinterface
`default_nettype wire

// File: rtl/datapath_unit_register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 2R/1W register file, combinational reads, async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [RF_AW-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RF_AW-1:0]  i_ra_addr,
    input  logic [RF_AW-1:0]  i_rb_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data
);
    localparam int c_NREGS = 2 ** RF_AW;

    logic [DATA_W-1:0] r_regs [c_NREGS];

    // Reads see only committed state; there is deliberately no write bypass.
    for (genvar g = 0; g < c_NREGS; g++) begin : g_regs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_regs[g] <= '0;
            end else if (i_we && (i_waddr == RF_AW'(g))) begin
                r_regs[g] <= i_wdata;
            end
        end
    end

    assign o_ra_data = r_regs[i_ra_addr];
    assign o_rb_data = r_regs[i_rb_addr];

endmodule
`default_nettype wire

// File: rtl/datapath_unit.sv
`default_nettype none
// ============================================================================
// Module      : datapath_unit
// Description : Register file, ALU with C/N/Z flags and 256x16 sync data RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_unit #(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int RF_AW  = datapath_pkg::RF_AW,
    parameter int DM_AW  = datapath_pkg::DM_AW
) (
    input  logic           Clk,
    input  logic           Reset,
    datapath_unit_if.slave bus
);
    import datapath_pkg::*;

    logic [DATA_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rb;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_wb_data;
    alu_op_e           w_op;

    logic [DATA_W-1:0] r_ram [2 ** DM_AW];
    logic [DATA_W-1:0] r_mem_q;
    logic [2:0]        r_flags;

    assign w_op      = alu_op_e'(bus.ALU_s0);
    assign w_wb_data = bus.RF_s ? r_mem_q : w_alu_res;

    register_file #(
        .DATA_W (DATA_W),
        .RF_AW  (RF_AW)
    ) u_register_file (
        .clk       (Clk),
        .rst_n     (Reset),
        .i_we      (bus.RF_W_en),
        .i_waddr   (bus.RF_W_Addr),
        .i_wdata   (w_wb_data),
        .i_ra_addr (bus.RF_Ra_Addr),
        .i_rb_addr (bus.RF_Rb_Addr),
        .o_ra_data (w_ra),
        .o_rb_data (w_rb)
    );

    // SUB is A + ~B + 1, so the carry out reads as "no borrow".
    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_sum     = {1'b0, w_ra} + {1'b0, w_rb};
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
            end
            ALU_SUB: begin
                w_sum     = {1'b0, w_ra} + {1'b0, ~w_rb} + {{DATA_W{1'b0}}, 1'b1};
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
            end
            ALU_PASS: w_alu_res = w_ra;
            ALU_AND:  w_alu_res = w_ra & w_rb;
            ALU_OR:   w_alu_res = w_ra | w_rb;
            ALU_XOR:  w_alu_res = w_ra ^ w_rb;
            ALU_NOT:  w_alu_res = ~w_ra;
            ALU_INC: begin
                w_sum     = {1'b0, w_ra} + {{DATA_W{1'b0}}, 1'b1};
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
            end
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_flags <= 3'b000;
        end else if (bus.RF_W_en && !bus.RF_s) begin
            r_flags[FLAG_Z] <= (w_alu_res == '0);
            r_flags[FLAG_N] <= w_alu_res[DATA_W-1];
            r_flags[FLAG_C] <= w_alu_c;
        end
    end

    // Storage array carries no reset; a write is simply dropped while Reset is low.
    always_ff @(posedge Clk) begin
        if (Reset && bus.D_Wr) begin
            r_ram[bus.D_Addr] <= w_ra;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_mem_q <= '0;
        end else begin
            r_mem_q <= r_ram[bus.D_Addr];
        end
    end

    assign bus.Ra_Data = w_ra;
    assign bus.Rb_Data = w_rb;
    assign bus.ALU_Out = w_alu_res;
    assign bus.Mem_Q   = r_mem_q;
    assign bus.Flags   = r_flags;

endmodule
`default_nettype wire

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Execution datapath directly downstream of the control unit.
- Consumes the control unit's per-cycle control word (D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0) and performs register-file reads and writes, ALU operations and data-memory load/store.
- Holds all architectural data state: 16x16 register file, 256x16 data RAM and ALU status flags.

Parameters:
DATA_W, 16, datapath word width
RF_AW, 4, register-file address width (2**RF_AW registers)
DM_AW, 8, data-memory address width (2**DM_AW words)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-low reset
D_Addr  in  DM_AW  data-memory address
D_Wr  in  1  data-memory write enable
RF_s  in  1  write-back select: 1 = memory read data, 0 = ALU result
RF_W_Addr  in  RF_AW  register write address
RF_W_en  in  1  register write enable
RF_Ra_Addr  in  RF_AW  read port A address
RF_Rb_Addr  in  RF_AW  read port B address
ALU_s0  in  3  ALU operation select
Ra_Data  out  DATA_W  register port A read data
Rb_Data  out  DATA_W  register port B read data
ALU_Out  out  DATA_W  combinational ALU result
Mem_Q  out  DATA_W  registered data-memory read data
Flags  out  3  {C, N, Z} status register

Behaviour:
- Reset low (async): all registers = 0x0000, Flags = 3'b000, Mem_Q = 0x0000. RAM contents are not reset. Release of Reset takes effect at the next rising edge.
- Register file reads are combinational.
  - Ra_Data = RF[RF_Ra_Addr]; Rb_Data = RF[RF_Rb_Addr].
  - R0 is an ordinary register (not hardwired to zero).
- Register file write: on rising edge when RF_W_en = 1, RF[RF_W_Addr] <= (RF_s ? Mem_Q : ALU_Out).
  - No write-to-read bypass: a same-cycle read of the written address returns the old value; the new value is visible the next cycle.
- ALU is combinational on A = Ra_Data, B = Rb_Data:
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 PASS A
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 NOT A
  - 111 INC A+1
- ALU arithmetic and width rules:
  - Result is truncated to DATA_W (wraps modulo 2**16).
  - Carry out is bit DATA_W of the 17-bit sum.
  - SUB carry = no-borrow (A >= B unsigned).
  - Logic ops and PASS produce C = 0.
- Flags update on rising edge only when RF_W_en = 1 and RF_s = 0 (ALU write-back). Otherwise Flags hold.
  - Z = (ALU_Out == 0)
  - N = ALU_Out[15]
  - C = carry as defined above
- Data memory: single port, synchronous.
  - Write: on rising edge when D_Wr = 1, RAM[D_Addr] <= Ra_Data (store source is always port A).
  - Read: Mem_Q <= RAM[D_Addr] every rising edge, giving 1-cycle latency. The control FSM must present D_Addr one cycle before the load write-back cycle.
  - Read-during-write to the same address: Mem_Q gets the OLD contents.
- Simultaneous D_Wr and RF_W_en in one cycle are legal and independent. A load write-back uses the Mem_Q value that is current before that edge.
- Reset asserted mid-operation: any pending write on that edge is discarded. A RAM write coincident with the reset assertion edge is not guaranteed.
- X-free: all outputs are defined after reset for any input combination.

Decomposition:
- Shared package datapath_pkg:
  - alu_op_e enum (ADD, SUB, PASS, AND, OR, XOR, NOT, INC; 3 bits)
  - DATA_W, RF_AW, DM_AW defaults
  - flag bit indices FLAG_Z = 0, FLAG_N = 1, FLAG_C = 2
- One natural sub-module: register_file (2 combinational read ports, 1 synchronous write port, async active-low clear).
- ALU and RAM stay inline.

Test Plan:
1. Reset low mid-run after writes -> all registers read 0x0000, Flags = 000, Mem_Q = 0x0000 immediately (async, no clock needed).
2. Write R1 = 0x0005 and R2 = 0x0003 via INC/ADD sequences, then ADD R1,R2 -> R3 -> next cycle R3 = 0x0008, Flags = 000. Same cycle, reading R3 still returns the old value.
3. R1 = 0xFFFF, R2 = 0x0001, ADD -> R4 -> R4 = 0x0000, Flags = {C=1, N=0, Z=1}. Then SUB R2-R1 -> 0x0002, C = 0.
4. Store R3 (0x0008) to D_Addr 0x2A with D_Wr = 1, then present D_Addr 0x2A -> Mem_Q = 0x0008 one cycle later. RF_s = 1, RF_W_en = 1 -> R5 = 0x0008, Flags unchanged.
5. Read-during-write: D_Addr = 0x10 holding 0x1234, D_Wr with Ra_Data = 0xBEEF -> Mem_Q = 0x1234 that edge, 0xBEEF the next edge.
6. Sweep all 8 ALU_s0 codes with A = 0x8001, B = 0x00FF:
   - ALU_Out = 0x8100, 0x7F02, 0x8001, 0x0001, 0x80FF, 0x80FE, 0x7FFE, 0x8002.
   - N flag matches bit 15 after each write-back.
